// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, types and write-port priority select
// for the multi-port register file.
package regfile_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_ENTRY = 32;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  // Match masks are zero-extended to this width (NWP <= 32).
  typedef logic [31:0] rf_mask_t;

  // Highest set index of a port-match mask, -1 if none.
  function automatic int rf_hi_sel(input rf_mask_t m);
    int s;
    s = -1;
    for (int k = 0; k < 32; k++)
      if (m[k]) s = k;
    return s;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending-write bit per register; set beats clear.
// Ports: clk, rst_n, bset_i/bsa_i (issue), clr_i (writeback), busy_o, any_busy_o.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int AW      = RF_AW,
  parameter int ENTRY   = RF_ENTRY,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bset_i,
  input  logic [AW-1:0]    bsa_i,
  input  logic [ENTRY-1:0] clr_i,
  output logic [ENTRY-1:0] busy_o,
  output logic             any_busy_o
);

  logic [ENTRY-1:0] busy_q;
  logic [ENTRY-1:0] busy_d;
  logic [ENTRY-1:0] set;

  always_comb begin
    set = '0;
    for (int e = 0; e < ENTRY; e++)
      set[e] = bset_i && (bsa_i == AW'(e))
               && !((ZERO_R0 != 0) && (e == 0));
  end

  // A fresh issue outranks the writeback of the older producer.
  assign busy_d = (busy_q & ~clr_i) | set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o     = busy_q;
  assign any_busy_o = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRP-read / NWP-write register file with busy scoreboard.
// Ports: CLK, RSTN, WEN/WA/DI (writes), RA/DOUT/RBUSY (reads),
// BSET/BSA (issue mark), ANY_BUSY. Macro REGFILE_BYPASS_EN enables
// same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int AW      = RF_AW,
  parameter int ENTRY   = RF_ENTRY,
  parameter int DW      = RF_DW,
  parameter int NRP     = 2,
  parameter int NWP     = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [NWP-1:0]    WEN,
  input  logic [NWP*AW-1:0] WA,
  input  logic [NWP*DW-1:0] DI,
  input  logic [NRP*AW-1:0] RA,
  output logic [NRP*DW-1:0] DOUT,
  output logic [NRP-1:0]    RBUSY,
  input  logic              BSET,
  input  logic [AW-1:0]     BSA,
  output logic              ANY_BUSY
);

  localparam logic [AW:0] ENT = (AW+1)'(ENTRY);

  logic [DW-1:0]    mem_q [ENTRY];
  logic [DW-1:0]    mem_d [ENTRY];
  logic [NWP-1:0]   acc;
  logic [ENTRY-1:0] wr_hit;
  logic [ENTRY-1:0] busy;
  logic             bset_ok;

  // A write is accepted only in range and never to a hardwired r0.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NWP; k++)
      acc[k] = WEN[k]
               && ({1'b0, WA[k*AW +: AW]} < ENT)
               && !((ZERO_R0 != 0) && (WA[k*AW +: AW] == '0));
  end

  assign bset_ok = BSET
                   && ({1'b0, BSA} < ENT)
                   && !((ZERO_R0 != 0) && (BSA == '0));

  // Ascending port loop: the highest index lands last and wins.
  always_comb begin
    mem_d  = mem_q;
    wr_hit = '0;
    for (int e = 0; e < ENTRY; e++)
      for (int k = 0; k < NWP; k++)
        if (acc[k] && (WA[k*AW +: AW] == AW'(e))) begin
          mem_d[e]  = DI[k*DW +: DW];
          wr_hit[e] = 1'b1;
        end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int e = 0; e < ENTRY; e++)
        mem_q[e] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  rf_scoreboard #(
    .AW      (AW),
    .ENTRY   (ENTRY),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk        (CLK),
    .rst_n      (RSTN),
    .bset_i     (BSET),
    .bsa_i      (BSA),
    .clr_i      (wr_hit),
    .busy_o     (busy),
    .any_busy_o (ANY_BUSY)
  );

`ifdef REGFILE_BYPASS_EN
  rf_mask_t hit_m [NRP];
  int       hit_s [NRP];
`endif

  always_comb begin
    DOUT  = '0;
    RBUSY = '0;
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NRP; j++) begin
      hit_m[j] = '0;
      hit_s[j] = -1;
    end
`endif
    for (int j = 0; j < NRP; j++) begin
      for (int e = 0; e < ENTRY; e++)
        if (RA[j*AW +: AW] == AW'(e)) begin
          DOUT[j*DW +: DW] = mem_q[e];
          RBUSY[j]         = busy[e];
        end
      if ((ZERO_R0 != 0) && (RA[j*AW +: AW] == '0))
        DOUT[j*DW +: DW] = '0;
`ifdef REGFILE_BYPASS_EN
      for (int k = 0; k < NWP; k++)
        hit_m[j][k] = acc[k]
                      && (WA[k*AW +: AW] == RA[j*AW +: AW]);
      hit_s[j] = rf_hi_sel(hit_m[j]);
      if (hit_s[j] >= 0) begin
        DOUT[j*DW +: DW] = DI[hit_s[j]*DW +: DW];
        RBUSY[j] = bset_ok && (BSA == RA[j*AW +: AW]);
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed + random checks of regfile_mp against an
// array-based reference model (ENTRY=16, NWP=2, ZERO_R0=1).
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int EN = 16;
  localparam int DW = 32;

  logic          CLK;
  logic          RSTN;
  logic [1:0]    WEN;
  logic [9:0]    WA;
  logic [63:0]   DI;
  logic [9:0]    RA;
  logic [63:0]   DOUT;
  logic [1:0]    RBUSY;
  logic          BSET;
  logic [4:0]    BSA;
  logic          ANY_BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_mem [EN];
  bit          m_busy [EN];

  regfile_mp #(
    .AW(AW), .ENTRY(EN), .DW(DW),
    .NRP(2), .NWP(2), .ZERO_R0(1)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .WEN(WEN), .WA(WA), .DI(DI),
    .RA(RA), .DOUT(DOUT), .RBUSY(RBUSY),
    .BSET(BSET), .BSA(BSA), .ANY_BUSY(ANY_BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit wr_ok(input int k);
    int a;
    a = int'(WA[k*AW +: AW]);
    return WEN[k] && a < EN && a != 0;
  endfunction

  function automatic logic [31:0] exp_rd(input int ra);
    logic [31:0] v;
    v = (ra < EN && ra != 0) ? m_mem[ra] : 32'h0;
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wr_ok(k) && int'(WA[k*AW +: AW]) == ra)
        v = DI[k*DW +: DW];
`endif
    return v;
  endfunction

  function automatic logic exp_rb(input int ra);
    logic b;
    b = (ra < EN) ? m_busy[ra] : 1'b0;
`ifdef REGFILE_BYPASS_EN
    for (int k = 0; k < 2; k++)
      if (wr_ok(k) && int'(WA[k*AW +: AW]) == ra)
        b = BSET && int'(BSA) == ra && ra != 0;
`endif
    return b;
  endfunction

  function automatic logic exp_any();
    int n;
    n = 0;
    for (int e = 0; e < EN; e++) n += m_busy[e];
    return n > 0;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < EN; e++) begin
      m_mem[e]  = '0;
      m_busy[e] = 0;
    end
  endtask

  task automatic model_clock();
    int a;
    for (int k = 0; k < 2; k++)
      if (wr_ok(k)) begin
        a = int'(WA[k*AW +: AW]);
        m_mem[a]  = DI[k*DW +: DW];
        m_busy[a] = 0;
      end
    a = int'(BSA);
    if (BSET && a < EN && a != 0) m_busy[a] = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout0"}, DOUT[31:0], exp_rd(int'(RA[4:0])));
    chk({tag, ".dout1"}, DOUT[63:32], exp_rd(int'(RA[9:5])));
    chk({tag, ".rbusy0"}, 32'(RBUSY[0]), 32'(exp_rb(int'(RA[4:0]))));
    chk({tag, ".rbusy1"}, 32'(RBUSY[1]), 32'(exp_rb(int'(RA[9:5]))));
    chk({tag, ".any"}, 32'(ANY_BUSY), 32'(exp_any()));
  endtask

  task automatic step(input string tag,
                      input logic [1:0] we,
                      input int a0, input logic [31:0] d0,
                      input int a1, input logic [31:0] d1,
                      input int r0, input int r1,
                      input logic bs, input int ba);
    WEN  = we;
    WA   = {5'(a1), 5'(a0)};
    DI   = {d1, d0};
    RA   = {5'(r1), 5'(r0)};
    BSET = bs;
    BSA  = 5'(ba);
    #1;
    check_all(tag);
    @(posedge CLK);
    if (RSTN) model_clock();
    #1;
  endtask

  task automatic idle_rd(input string tag, input int r0, input int r1);
    step(tag, 2'b00, 0, 0, 0, 0, r0, r1, 1'b0, 0);
  endtask

  initial begin
    RSTN = 1'b0;
    WEN = '0; WA = '0; DI = '0; RA = '0;
    BSET = 1'b0; BSA = '0;
    model_reset();
    #3;
    chk("reset.dout0", DOUT[31:0], 32'h0);
    chk("reset.any", 32'(ANY_BUSY), 32'h0);
    #9 RSTN = 1'b1;
    @(posedge CLK); #1;

    // write r3, read same cycle and next cycle
    step("wr3", 2'b01, 3, 32'h12345678, 0, 0, 3, 3, 1'b0, 0);
    idle_rd("rd3", 3, 3);
    RA = {5'd3, 5'd3}; #1;
    chk("rd3.p0", DOUT[31:0], 32'h12345678);
    chk("rd3.p1", DOUT[63:32], 32'h12345678);

    // both ports write r7: port 1 wins
    step("conf", 2'b11, 7, 32'hAAAA0000, 7, 32'h5555FFFF, 7, 6, 1'b0, 0);
    idle_rd("conf.rd", 7, 7);
    RA = {5'd7, 5'd7}; #1;
    chk("conf.r7", DOUT[31:0], 32'h5555FFFF);

    // hardwired r0
    step("r0wr", 2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1'b1, 0);
    idle_rd("r0rd", 0, 0);
    RA = '0; #1;
    chk("r0.dout", DOUT[31:0], 32'h0);
    chk("r0.rbusy", 32'(RBUSY[0]), 32'h0);
    chk("r0.any", 32'(ANY_BUSY), 32'h0);

    // scoreboard set / set-beats-clear / clear
    step("sb.set", 2'b00, 0, 0, 0, 0, 9, 9, 1'b1, 9);
    RA = {5'd9, 5'd9}; #1;
    chk("sb.busy", 32'(RBUSY[0]), 32'h1);
    chk("sb.any", 32'(ANY_BUSY), 32'h1);
    step("sb.both", 2'b01, 9, 32'h99, 0, 0, 9, 9, 1'b1, 9);
    RA = {5'd9, 5'd9}; #1;
    chk("sb.stay", 32'(RBUSY[0]), 32'h1);
    step("sb.clr", 2'b10, 0, 0, 9, 32'h999, 9, 9, 1'b0, 0);
    RA = {5'd9, 5'd9}; #1;
    chk("sb.cleared", 32'(RBUSY[1]), 32'h0);
    chk("sb.anyclr", 32'(ANY_BUSY), 32'h0);

    // out of range write and read
    step("oor.wr", 2'b01, 20, 32'hCAFEF00D, 0, 0, 20, 4, 1'b1, 20);
    RA = {5'd4, 5'd20}; #1;
    chk("oor.dout", DOUT[31:0], 32'h0);
    chk("oor.rbusy", 32'(RBUSY[0]), 32'h0);
    for (int e = 0; e < EN; e += 2)
      idle_rd("sweep", e, e + 1);

    // async reset mid-write clears everything
    step("pre5", 2'b01, 5, 32'h11, 0, 0, 5, 5, 1'b1, 11);
    WEN = 2'b01; WA = 10'd5; DI = {32'h0, 32'hDEADBEEF};
    RA = {5'd11, 5'd5}; BSET = 1'b0;
    #2 RSTN = 1'b0;
    #1;
    chk("arst.dout", DOUT[31:0], 32'h0);
    chk("arst.any", 32'(ANY_BUSY), 32'h0);
    model_reset();
    @(posedge CLK); #1;
    WEN = '0;
    #2 RSTN = 1'b1;
    #1;
    chk("rst.r5", DOUT[31:0], 32'h0);
    chk("rst.rbusy", 32'(RBUSY[1]), 32'h0);
    chk("rst.any", 32'(ANY_BUSY), 32'h0);
    @(posedge CLK); #1;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           2'($urandom_range(0, 3)),
           int'($urandom_range(0, 19)), $urandom,
           int'($urandom_range(0, 19)), $urandom,
           int'($urandom_range(0, 19)), int'($urandom_range(0, 19)),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, 19)));
    end
    for (int e = 0; e < EN; e += 2)
      idle_rd("final", e, e + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the core's 2-read/1-write register file.
- Supports configurable read and write port counts, an optional hardwired-zero register, and a per-register pending-write scoreboard.
- Sits in the decode/writeback stages of the RISC_TOY pipeline: operands are read, and in-flight destination registers are tracked for hazard detection.

Parameters:
AW, 5, register address width
ENTRY, 32, number of registers (≤ 2**AW)
DW, 32, data width
NRP, 2, number of read ports
NWP, 1, number of write ports
ZERO_R0, 0, 1 = register 0 always reads 0, and writes and busy sets to it are ignored

Ports:
CLK  in  1  clock, rising edge
RSTN  in  1  asynchronous active-low reset
WEN  in  NWP  write enable per write port
WA  in  NWP*AW  write addresses, port k at [k*AW +: AW]
DI  in  NWP*DW  write data, port k at [k*DW +: DW]
RA  in  NRP*AW  read addresses, port j at [j*AW +: AW]
DOUT  out  NRP*DW  read data per port
RBUSY  out  NRP  scoreboard busy bit of RA[j]
BSET  in  1  mark register BSA as pending (instruction issue)
BSA  in  AW  address to mark pending
ANY_BUSY  out  1  OR of all scoreboard bits

Behaviour:
Clock and reset:
- Single clock domain. The decided interface is one clock; reset is asynchronous and active-low (CLK, RSTN).
- Reset, asserted at any time including mid-write, asynchronously clears all ENTRY registers to 0 and all busy bits to 0.
- After reset, DOUT = 0 for every address, RBUSY = 0 and ANY_BUSY = 0.

Reads:
- Combinational, 0-cycle latency.
- DOUT[j] = mem[RA[j]].
- RA ≥ ENTRY returns 0 and RBUSY = 0.

Writes:
- On a CLK rising edge, each port with WEN[k] = 1 and WA[k] < ENTRY updates mem[WA[k]] <= DI[k]. The new value is visible to reads in the next cycle.
- Two ports writing the same address in the same cycle: the highest port index wins.
- WA ≥ ENTRY: the write is dropped silently.
- ZERO_R0 = 1: writes to address 0 are dropped and DOUT for address 0 is forced to 0.

Scoreboard:
- One busy bit per entry.
- A rising edge with BSET = 1 sets busy[BSA].
- Any accepted write to address a clears busy[a].
- Set and clear of the same address in the same cycle: the set wins, because a new producer has issued.
- BSET on an already-busy register keeps it busy; there is no counting.
- ZERO_R0 = 1: BSET to address 0 is ignored.
- RBUSY[j] = busy[RA[j]].
- ANY_BUSY = |busy. It is used for pipeline drain and flush checks.

Simultaneous read and write to the same address: without the optional feature, the read returns the old value.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined:
  - A read whose RA[j] matches an accepted write this cycle returns that write's DI (highest matching port index). This is combinational write-to-read forwarding.
  - RBUSY[j] is forced to 0 for that read, unless BSET targets the same address this cycle.
  - Removes one writeback bubble.
- Undefined:
  - Reads return the stored value only.
  - RBUSY reflects the registered busy bit only.
  - The pipeline must stall one cycle on a read-after-write in the same cycle.

Decomposition:
- Package regfile_pkg:
  - RF_AW / RF_DW / RF_ENTRY defaults
  - typedefs rf_addr_t and rf_data_t
  - function for write-port priority select (highest index match)
- Natural sub-module: rf_scoreboard.
  - Holds the busy bits, set/clear priority and ANY_BUSY.
  - regfile_mp instantiates it alongside the storage array and read muxes.

Test Plan:
- Reset: RSTN = 0 mid-write of 0xDEADBEEF to r5 -> after release, DOUT for r5 = 0, RBUSY = 0, ANY_BUSY = 0.
- Write/read: WEN = 1, WA = 3, DI = 0x12345678 -> same cycle DOUT(RA = 3) = 0 (bypass off) or 0x12345678 (bypass on); next cycle 0x12345678 on both read ports.
- Port conflict (NWP = 2): both ports write r7, port0 = 0xAAAA0000 and port1 = 0x5555FFFF -> r7 = 0x5555FFFF.
- ZERO_R0 = 1: write 0xFFFFFFFF to r0 and BSET BSA = 0 -> DOUT = 0, RBUSY = 0.
- Scoreboard: BSET r9 -> next cycle RBUSY(r9) = 1 and ANY_BUSY = 1. Then write r9 together with BSET r9 -> stays busy. Then write r9 alone -> busy clears and ANY_BUSY = 0.
- Out of range (ENTRY = 16, AW = 5): write WA = 20 -> no register changes; DOUT(RA = 20) = 0.
